// File: rtl/interleaver_pp_writer_if.sv
// Bus bundle for the ping-pong interleaver write side.
// master = writer, slave = FIFO / buffer / reader environment.
interface interleaver_pp_writer_if #(
    parameter int DATA_WIDTH = 1,
    parameter int AW         = 7
);
    logic                  MODE;
    logic [DATA_WIDTH-1:0] FIFO_IN_DATA;
    logic                  FIFO_IN_EMPTY;
    logic                  FIFO_IN_RE;
    logic [DATA_WIDTH-1:0] BUFF_DATA;
    logic [AW-1:0]         BUFF_ADDR;
    logic                  BUFF_BANK;
    logic                  BUFF_WE;
    logic [1:0]            FRAME_READY;
    logic                  NEXT_READ_BANK;
    logic [1:0]            FRAME_ACK;

    modport master (
        input  MODE, FIFO_IN_DATA, FIFO_IN_EMPTY, FRAME_ACK,
        output FIFO_IN_RE, BUFF_DATA, BUFF_ADDR, BUFF_BANK,
        output BUFF_WE, FRAME_READY, NEXT_READ_BANK
    );

    modport slave (
        output MODE, FIFO_IN_DATA, FIFO_IN_EMPTY, FRAME_ACK,
        input  FIFO_IN_RE, BUFF_DATA, BUFF_ADDR, BUFF_BANK,
        input  BUFF_WE, FRAME_READY, NEXT_READ_BANK
    );
endinterface

// File: rtl/interleaver_pp_writer.sv
// Write side of a ping-pong interleaver matrix buffer.
// Drains a 1-cycle-latency FIFO into two banks with permuted addresses.
module interleaver_pp_writer #(
    parameter int DATA_WIDTH = 1,
    parameter int ROW_NUMBER = 10,
    parameter int COL_NUMBER = 7
) (
    input  logic                   CLK,
    input  logic                   RESET,
    interleaver_pp_writer_if.master bus
);
    localparam int DEPTH = ROW_NUMBER * COL_NUMBER;
    localparam int AW    = $clog2(DEPTH);
    localparam int RW    = $clog2(ROW_NUMBER);
    localparam int CW    = $clog2(COL_NUMBER);

    logic [RW-1:0]         row_q, row_d;
    logic [CW-1:0]         col_q, col_d;
    logic                  bank_q, bank_d;
    logic                  mode_q, mode_d;
    logic                  init_q;

    logic                  s1_vld_q;
    logic [AW-1:0]         s1_addr_q;
    logic                  s1_bank_q;
    logic                  s1_last_q;

    logic                  we_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [AW-1:0]         addr_q;
    logic                  wbank_q;
    logic                  last_q;

    logic [1:0]            rdy_q, rdy_d;
    logic                  nrb_q, nrb_d;

    logic                  re;
    logic                  first;
    logic                  row_end;
    logic                  col_end;
    logic                  last;
    logic                  cur_mode;
    logic [AW-1:0]         addr;

    // Issue decision and address of the element being requested.
    always_comb begin
        first    = (row_q == '0) && (col_q == '0);
        row_end  = row_q == RW'(ROW_NUMBER - 1);
        col_end  = col_q == CW'(COL_NUMBER - 1);
        last     = row_end && col_end;
        cur_mode = first ? bus.MODE : mode_q;
        re       = !RESET && !init_q && !bus.FIFO_IN_EMPTY
                   && !rdy_q[bank_q];
        if (cur_mode)
            addr = AW'(row_q) * AW'(COL_NUMBER) + AW'(col_q);
        else
            addr = AW'(col_q) * AW'(ROW_NUMBER) + AW'(row_q);
    end

    // Element counters, frame mode latch and issue bank.
    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        bank_d = bank_q;
        mode_d = mode_q;
        if (re) begin
            if (first)
                mode_d = bus.MODE;
            if (last)
                bank_d = ~bank_q;
            if (cur_mode) begin
                row_d = row_end ? '0 : row_q + 1'b1;
                if (row_end)
                    col_d = col_end ? '0 : col_q + 1'b1;
            end else begin
                col_d = col_end ? '0 : col_q + 1'b1;
                if (col_end)
                    row_d = row_end ? '0 : row_q + 1'b1;
            end
        end
    end

    // Bank ownership: set on last write, cleared by a valid ack.
    always_comb begin
        rdy_d = rdy_q & ~bus.FRAME_ACK;
        if (we_q && last_q)
            rdy_d[wbank_q] = 1'b1;
        nrb_d = nrb_q ^ (bus.FRAME_ACK[nrb_q] & rdy_q[nrb_q]);
    end

    // State and two-stage write pipeline.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            row_q     <= '0;
            col_q     <= '0;
            bank_q    <= 1'b0;
            mode_q    <= 1'b0;
            init_q    <= 1'b1;
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_bank_q <= 1'b0;
            s1_last_q <= 1'b0;
            we_q      <= 1'b0;
            data_q    <= '0;
            addr_q    <= '0;
            wbank_q   <= 1'b0;
            last_q    <= 1'b0;
            rdy_q     <= 2'b00;
            nrb_q     <= 1'b0;
        end else begin
            row_q     <= row_d;
            col_q     <= col_d;
            bank_q    <= bank_d;
            mode_q    <= mode_d;
            init_q    <= 1'b0;
            s1_vld_q  <= re;
            s1_addr_q <= addr;
            s1_bank_q <= bank_q;
            s1_last_q <= last;
            we_q      <= s1_vld_q;
            data_q    <= bus.FIFO_IN_DATA;
            addr_q    <= s1_addr_q;
            wbank_q   <= s1_bank_q;
            last_q    <= s1_vld_q && s1_last_q;
            rdy_q     <= rdy_d;
            nrb_q     <= nrb_d;
        end
    end

    assign bus.FIFO_IN_RE     = re;
    assign bus.BUFF_WE        = we_q;
    assign bus.BUFF_DATA      = data_q;
    assign bus.BUFF_ADDR      = addr_q;
    assign bus.BUFF_BANK      = wbank_q;
    assign bus.FRAME_READY    = rdy_q;
    assign bus.NEXT_READ_BANK = nrb_q;
endmodule

// File: tb/tb_interleaver_pp_writer.sv
// Scoreboard bench for interleaver_pp_writer (ROW=3, COL=2).
// Directed frames; monitor pops expected writes on every BUFF_WE.
module tb_interleaver_pp_writer;
    localparam int DW   = 8;
    localparam int ROWS = 3;
    localparam int COLS = 2;
    localparam int AW   = 3;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    interleaver_pp_writer_if #(.DATA_WIDTH(DW), .AW(AW)) bus ();

    interleaver_pp_writer #(
        .DATA_WIDTH(DW),
        .ROW_NUMBER(ROWS),
        .COL_NUMBER(COLS)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus.master)
    );

    logic [DW-1:0] fifo  [$];
    logic [11:0]   exp_q [$];
    int            total = 0;
    int            bad   = 0;
    int            we_cnt = 0;
    int            cyc   = 0;
    logic          gap_en  = 1'b0;
    logic          gap_tgl = 1'b0;
    logic [7:0]    sym   = 8'h11;
    logic [2:0]    tbl0 [6] = '{3'd0, 3'd3, 3'd1, 3'd4, 3'd2, 3'd5};
    logic [2:0]    tbl1 [6] = '{3'd0, 3'd2, 3'd4, 3'd1, 3'd3, 3'd5};

    // Standard FIFO model: data one cycle after RE, registered empty.
    always @(posedge CLK) begin
        int n;
        cyc     <= cyc + 1;
        gap_tgl <= ~gap_tgl;
        n = fifo.size();
        if (bus.FIFO_IN_RE && n > 0) begin
            bus.FIFO_IN_DATA <= fifo.pop_front();
            n = n - 1;
        end
        bus.FIFO_IN_EMPTY <= (n == 0) || (gap_en && gap_tgl);
    end

    // Monitor: every buffer write is checked against the scoreboard.
    always @(negedge CLK) begin
        logic [11:0] act;
        logic [11:0] e;
        if (bus.BUFF_WE) begin
            act = {bus.BUFF_BANK, bus.BUFF_ADDR, bus.BUFF_DATA};
            we_cnt = we_cnt + 1;
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL wr_unexpected: got %h, none required", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    bad = bad + 1;
                    $display("FAIL wr_data: got %h required %h", act, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] ex);
        total = total + 1;
        if (act !== ex) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h required %0h", nm, act, ex);
        end
    endtask

    task automatic push(input logic b, input logic [2:0] a,
                        input logic keep);
        fifo.push_back(sym);
        if (keep)
            exp_q.push_back({b, a, sym});
        sym = sym + 8'h07;
    endtask

    task automatic push_frames(input int n, input logic b0,
                               input logic md);
        logic       b;
        logic [2:0] a;
        for (int i = 0; i < n; i++) begin
            b = b0 ^ (((i / 6) % 2) == 1);
            a = md ? tbl1[i % 6] : tbl0[i % 6];
            push(b, a, 1'b1);
        end
    endtask

    task automatic wait_re(input string nm);
        bit hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge CLK);
            hit = bus.FIFO_IN_RE;
        end
        chk(nm, 32'(hit), 32'd1);
    endtask

    task automatic wait_we(input string nm);
        bit hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge CLK);
            hit = bus.BUFF_WE;
        end
        chk(nm, 32'(hit), 32'd1);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 80 && exp_q.size() != 0; i++)
            @(negedge CLK);
        chk(nm, 32'(exp_q.size()), 32'd0);
        @(negedge CLK);
    endtask

    task automatic ack(input logic [1:0] a);
        bus.FRAME_ACK = a;
        @(negedge CLK);
        bus.FRAME_ACK = 2'b00;
    endtask

    initial begin
        int t0;
        int base;
        bit hit;
        bus.MODE = 1'b0;
        bus.FRAME_ACK = 2'b00;

        // Reset and MODE=0 frame into bank 0.
        repeat (2) @(negedge CLK);
        push_frames(6, 1'b0, 1'b0);
        repeat (2) @(negedge CLK);
        chk("rst_we", 32'(bus.BUFF_WE), 32'd0);
        chk("rst_re", 32'(bus.FIFO_IN_RE), 32'd0);
        chk("rst_ready", 32'(bus.FRAME_READY), 32'd0);
        chk("rst_nrb", 32'(bus.NEXT_READ_BANK), 32'd0);
        chk("rst_addr", 32'(bus.BUFF_ADDR), 32'd0);
        RESET = 1'b0;
        #1;
        chk("post_rst_re", 32'(bus.FIFO_IN_RE), 32'd0);
        wait_re("m0_re_seen");
        t0 = cyc;
        wait_we("m0_we_seen");
        chk("lat_re_we", 32'(cyc - t0), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("m0_burst_we", 32'(bus.BUFF_WE), 32'd1);
        end
        @(negedge CLK);
        chk("m0_ready", 32'(bus.FRAME_READY), 32'd1);
        chk("m0_nrb", 32'(bus.NEXT_READ_BANK), 32'd0);
        ack(2'b01);
        chk("ack0_ready", 32'(bus.FRAME_READY), 32'd0);
        chk("ack0_nrb", 32'(bus.NEXT_READ_BANK), 32'd1);
        ack(2'b10);
        chk("spur_ready", 32'(bus.FRAME_READY), 32'd0);
        chk("spur_nrb", 32'(bus.NEXT_READ_BANK), 32'd1);

        // MODE=1 frame into bank 1, MODE flipped after first issue.
        bus.MODE = 1'b1;
        push_frames(6, 1'b1, 1'b1);
        wait_re("m1_re_seen");
        @(posedge CLK);
        #1 bus.MODE = 1'b0;
        drain("m1_drain");
        chk("m1_ready", 32'(bus.FRAME_READY), 32'd2);
        ack(2'b10);
        chk("ack1_ready", 32'(bus.FRAME_READY), 32'd0);
        chk("ack1_nrb", 32'(bus.NEXT_READ_BANK), 32'd0);

        // Ping-pong: 18 symbols, no ack until both banks full.
        push_frames(18, 1'b0, 1'b0);
        wait_we("pp_we_seen");
        for (int i = 0; i < 11; i++) begin
            @(negedge CLK);
            chk("pp_no_gap", 32'(bus.BUFF_WE), 32'd1);
        end
        repeat (4) @(negedge CLK);
        chk("pp_ready", 32'(bus.FRAME_READY), 32'd3);
        chk("pp_stall_re", 32'(bus.FIFO_IN_RE), 32'd0);
        chk("pp_left", 32'(exp_q.size()), 32'd6);
        ack(2'b01);
        chk("pp_ack_ready", 32'(bus.FRAME_READY), 32'd2);
        chk("pp_ack_nrb", 32'(bus.NEXT_READ_BANK), 32'd1);
        chk("pp_resume_re", 32'(bus.FIFO_IN_RE), 32'd1);
        drain("pp_drain");
        chk("pp_ready2", 32'(bus.FRAME_READY), 32'd3);
        ack(2'b11);
        chk("both_ready", 32'(bus.FRAME_READY), 32'd0);
        chk("both_nrb", 32'(bus.NEXT_READ_BANK), 32'd0);

        // Empty gaps every other cycle, frame into bank 1.
        gap_en = 1'b1;
        base = we_cnt;
        push_frames(6, 1'b1, 1'b0);
        hit = 0;
        for (int i = 0; i < 80 && !hit; i++) begin
            @(negedge CLK);
            hit = bus.FRAME_READY[1];
        end
        chk("gap_ready_seen", 32'(hit), 32'd1);
        chk("gap_we_cnt", 32'(we_cnt - base), 32'd6);
        chk("gap_ready", 32'(bus.FRAME_READY), 32'd2);
        gap_en = 1'b0;

        // Reset mid-frame with bank 1 still owned by the reader.
        push(1'b0, 3'd0, 1'b1);
        push(1'b0, 3'd3, 1'b0);
        push(1'b0, 3'd1, 1'b0);
        wait_we("mid_we_seen");
        RESET = 1'b1;
        fifo.delete();
        @(negedge CLK);
        chk("mid_rst_we", 32'(bus.BUFF_WE), 32'd0);
        chk("mid_rst_ready", 32'(bus.FRAME_READY), 32'd0);
        chk("mid_rst_re", 32'(bus.FIFO_IN_RE), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("mid_no_we", 32'(bus.BUFF_WE), 32'd0);
        end
        chk("mid_sb_empty", 32'(exp_q.size()), 32'd0);
        push_frames(6, 1'b0, 1'b0);
        drain("mid_drain");
        chk("mid_new_ready", 32'(bus.FRAME_READY), 32'd1);
        chk("mid_new_nrb", 32'(bus.NEXT_READ_BANK), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
